// File: rtl/spi_slave_xcvr.sv
// SPI mode-0 slave transceiver: synchronised pins, MSB-first shifting, one-deep TX holding buffer.
// state    | meaning
// IDLE     | CSN high, MISO low, waiting for chip select
// SHIFT    | CSN low, shifting bits on synced SCLK edges
// WAIT_CS  | left reset with CSN already low; edges ignored until CSN rises
module spi_slave_xcvr #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              SPI_SCLK,
    input  logic              SPI_CSN,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    input  logic [DATA_W-1:0] tx_wr_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_rd_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_WAIT_CS = 2'd2;

    logic [1:0]             state;
    logic [SYNC_STAGES-1:0] sclk_pipe;
    logic [SYNC_STAGES-1:0] csn_pipe;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic                   sclk_hist;
    logic                   sclk_s;
    logic                   csn_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-2:0]      rx_sh;
    logic [DATA_W-1:0]      tx_sh;
    logic [DATA_W-1:0]      tx_buf;
    logic                   post_rst;
    logic                   load_ev;
    logic [DATA_W-1:0]      load_val;
    logic                   underrun_now;

    // Synchronisers sample continuously so the CSN level is already valid when reset releases.
    always_ff @(posedge sclk) begin
        sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], SPI_SCLK};
        csn_pipe  <= {csn_pipe[SYNC_STAGES-2:0], SPI_CSN};
        mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], SPI_MOSI};
        sclk_hist <= sclk_pipe[SYNC_STAGES-1];
    end

    assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
    assign csn_s     = csn_pipe[SYNC_STAGES-1];
    assign mosi_s    = mosi_pipe[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign sclk_fall = ~sclk_s & sclk_hist;

    always_comb begin
        load_ev = 1'b0;
        if (state == ST_IDLE && !csn_s && !post_rst)
            load_ev = 1'b1;
        else if (state == ST_SHIFT && !csn_s && !sclk_rise && sclk_fall && bit_cnt == '0)
            load_ev = 1'b1;

        if (!tx_ready)
            load_val = tx_buf;
        else if (tx_load)
            load_val = tx_wr_data;
        else
            load_val = '0;

        underrun_now = load_ev & tx_ready & ~tx_load;
    end

    // A shifter load drains a full buffer; an empty buffer can be bypassed by a same-cycle tx_load.
    always_ff @(posedge sclk) begin
        if (rst) begin
            tx_ready <= 1'b1;
            tx_buf   <= '0;
        end else if (load_ev && !tx_ready) begin
            tx_ready <= 1'b1;
        end else if (tx_ready && tx_load && !load_ev) begin
            tx_buf   <= tx_wr_data;
            tx_ready <= 1'b0;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            rx_rd_data  <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
            post_rst    <= 1'b1;
        end else begin
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= underrun_now;
            post_rst    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!csn_s) begin
                        if (post_rst) begin
                            state <= ST_WAIT_CS;
                        end else begin
                            state   <= ST_SHIFT;
                            tx_sh   <= load_val;
                            bit_cnt <= '0;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (csn_s) begin
                        state <= ST_IDLE;
                        if (bit_cnt != '0)
                            frame_err <= 1'b1;
                        bit_cnt <= '0;
                    end else if (sclk_rise) begin
                        rx_sh <= {rx_sh[DATA_W-3:0], mosi_s};
                        if (bit_cnt == LAST_BIT) begin
                            rx_rd_data <= {rx_sh, mosi_s};
                            rx_valid   <= 1'b1;
                            bit_cnt    <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt != '0)
                            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                        else
                            tx_sh <= load_val;
                    end
                end
                ST_WAIT_CS: begin
                    if (csn_s)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign SPI_MISO = (state == ST_SHIFT) & tx_sh[DATA_W-1];
    assign busy     = (state == ST_SHIFT);

endmodule

// File: tb/tb_spi_slave_xcvr.sv
// Bench for spi_slave_xcvr: a mode-0 master at sclk/8 drives directed frames; a monitor scores
// received bytes and captured MISO bytes against queues of expected values.
module tb_spi_slave_xcvr;

    logic       sclk = 1'b0;
    logic       rst = 1'b1;
    logic       SPI_SCLK = 1'b0;
    logic       SPI_CSN = 1'b1;
    logic       SPI_MOSI = 1'b0;
    logic       SPI_MISO;
    logic [7:0] tx_wr_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_rd_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       frame_err;
    logic       busy;

    spi_slave_xcvr #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .sclk        (sclk),
        .rst         (rst),
        .SPI_SCLK    (SPI_SCLK),
        .SPI_CSN     (SPI_CSN),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_MISO    (SPI_MISO),
        .tx_wr_data  (tx_wr_data),
        .tx_load     (tx_load),
        .tx_ready    (tx_ready),
        .rx_rd_data  (rx_rd_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 sclk = ~sclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int n_rxv = 0;
    int n_und = 0;
    int n_fe = 0;
    int b_rxv, b_und, b_fe;
    logic [7:0] rx_q[$];
    logic [7:0] miso_exp_q[$];
    logic [7:0] miso_got_q[$];
    logic [7:0] mon_exp;
    logic [7:0] mon_got;

    always @(posedge sclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    always @(negedge sclk) begin
        if (rx_valid) begin
            n_rxv++;
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected got=%02h exp=none", rx_rd_data);
            end else begin
                mon_exp = rx_q.pop_front();
                if (rx_rd_data !== mon_exp) begin
                    errors++;
                    $display("FAIL rx_byte got=%02h exp=%02h", rx_rd_data, mon_exp);
                end
            end
            checks++;
            if (cyc - last_rise_cyc > 4) begin
                errors++;
                $display("FAIL rx_latency got=%0d exp<=4", cyc - last_rise_cyc);
            end
        end
        if (tx_underrun) n_und++;
        if (frame_err) n_fe++;
        while (miso_got_q.size() > 0) begin
            mon_got = miso_got_q.pop_front();
            checks++;
            if (miso_exp_q.size() == 0) begin
                errors++;
                $display("FAIL miso_unexpected got=%02h exp=none", mon_got);
            end else begin
                mon_exp = miso_exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL miso_byte got=%02h exp=%02h", mon_got, mon_exp);
                end
            end
        end
    end

    task automatic preload(input logic [7:0] v);
        @(negedge sclk);
        tx_wr_data = v;
        tx_load = 1'b1;
        @(negedge sclk);
        tx_load = 1'b0;
    endtask

    task automatic cs_fall();
        @(negedge sclk);
        SPI_CSN = 1'b0;
        repeat (6) @(negedge sclk);
    endtask

    // The closing SCLK fall and CSN rise share a pin edge, so CSN wins and no extra reload happens.
    task automatic spi_byte(input logic [7:0] d, input int nbits, input bit last, input bit keep);
        logic [7:0] got;
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            @(negedge sclk);
            SPI_MOSI = d[7-i];
            repeat (3) @(negedge sclk);
            got[7-i] = SPI_MISO;
            SPI_SCLK = 1'b1;
            last_rise_cyc = cyc;
            repeat (4) @(negedge sclk);
            SPI_SCLK = 1'b0;
            if (last && i == nbits - 1) SPI_CSN = 1'b1;
        end
        if (keep) miso_got_q.push_back(got);
        if (last) repeat (10) @(negedge sclk);
    endtask

    task automatic frame1(input logic [7:0] mosi, input logic [7:0] miso);
        rx_q.push_back(mosi);
        miso_exp_q.push_back(miso);
        cs_fall();
        spi_byte(mosi, 8, 1'b1, 1'b1);
    endtask

    task automatic base();
        b_rxv = n_rxv;
        b_und = n_und;
        b_fe = n_fe;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge sclk);
        rst = 1'b0;
        @(negedge sclk);
        chk("rst_miso", SPI_MISO, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_data", rx_rd_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_underrun", tx_underrun, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);

        // single byte with preloaded reply
        base();
        preload(8'hA5);
        chk("t1_ready_full", tx_ready, 0);
        rx_q.push_back(8'h3C);
        miso_exp_q.push_back(8'hA5);
        cs_fall();
        chk("t1_busy", busy, 1);
        chk("t1_ready_drained", tx_ready, 1);
        spi_byte(8'h3C, 8, 1'b1, 1'b1);
        chk("t1_rx_data", rx_rd_data, 8'h3C);
        chk("t1_rxv_cnt", n_rxv - b_rxv, 1);
        chk("t1_und_cnt", n_und - b_und, 0);
        chk("t1_busy_end", busy, 0);

        // two bytes, second reply loaded mid-frame
        base();
        preload(8'h11);
        rx_q.push_back(8'hF0);
        rx_q.push_back(8'h0F);
        miso_exp_q.push_back(8'h11);
        miso_exp_q.push_back(8'h22);
        fork
            begin
                cs_fall();
                spi_byte(8'hF0, 8, 1'b0, 1'b1);
                spi_byte(8'h0F, 8, 1'b1, 1'b1);
            end
            begin
                int w;
                w = 0;
                while (tx_ready !== 1'b1 && w < 200) begin
                    @(negedge sclk);
                    w++;
                end
                chk("t2_ready_wait", (w < 200) ? 1 : 0, 1);
                tx_wr_data = 8'h22;
                tx_load = 1'b1;
                @(negedge sclk);
                tx_load = 1'b0;
            end
        join
        chk("t2_rx_data", rx_rd_data, 8'h0F);
        chk("t2_rxv_cnt", n_rxv - b_rxv, 2);
        chk("t2_und_cnt", n_und - b_und, 0);

        // underrun: no reply loaded
        base();
        frame1(8'h55, 8'h00);
        chk("t3_rx_data", rx_rd_data, 8'h55);
        chk("t3_und_cnt", n_und - b_und, 1);
        chk("t3_rxv_cnt", n_rxv - b_rxv, 1);

        // aborted byte after five clocks, then a clean frame
        base();
        cs_fall();
        spi_byte(8'hB7, 5, 1'b1, 1'b0);
        chk("t4_fe_cnt", n_fe - b_fe, 1);
        chk("t4_rxv_cnt", n_rxv - b_rxv, 0);
        chk("t4_rx_held", rx_rd_data, 8'h55);
        chk("t4_und_cnt", n_und - b_und, 1);
        preload(8'h5A);
        frame1(8'h81, 8'h5A);
        chk("t4_rx_next", rx_rd_data, 8'h81);
        chk("t4_rxv_next", n_rxv - b_rxv, 1);
        chk("t4_fe_total", n_fe - b_fe, 1);

        // reset mid-byte with CSN held low
        base();
        cs_fall();
        spi_byte(8'hFF, 3, 1'b0, 1'b0);
        @(negedge sclk);
        rst = 1'b1;
        @(negedge sclk);
        rst = 1'b0;
        chk("t5_rst_rx", rx_rd_data, 0);
        chk("t5_rst_ready", tx_ready, 1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_miso", SPI_MISO, 0);
        chk("t5_rst_rxv", rx_valid, 0);
        spi_byte(8'hFF, 8, 1'b0, 1'b0);
        chk("t5_wait_busy", busy, 0);
        chk("t5_wait_miso", SPI_MISO, 0);
        chk("t5_wait_rx", rx_rd_data, 0);
        chk("t5_wait_rxv", n_rxv - b_rxv, 0);
        @(negedge sclk);
        SPI_CSN = 1'b1;
        repeat (10) @(negedge sclk);
        preload(8'h96);
        frame1(8'hC3, 8'h96);
        chk("t5_rx_next", rx_rd_data, 8'hC3);
        chk("t5_rxv_cnt", n_rxv - b_rxv, 1);
        chk("t5_fe_cnt", n_fe - b_fe, 0);
        chk("t5_und_cnt", n_und - b_und, 1);

        // load while full is ignored
        base();
        preload(8'h77);
        chk("t6_ready_full", tx_ready, 0);
        @(negedge sclk);
        tx_wr_data = 8'hEE;
        tx_load = 1'b1;
        @(negedge sclk);
        tx_load = 1'b0;
        chk("t6_ready_still", tx_ready, 0);
        frame1(8'h6B, 8'h77);
        chk("t6_rx_data", rx_rd_data, 8'h6B);
        chk("t6_und_cnt", n_und - b_und, 0);

        repeat (4) @(negedge sclk);
        chk("end_rx_q_empty", rx_q.size(), 0);
        chk("end_miso_q_empty", miso_exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
